mem_arbiter: RTL and testbench

- Shares the single physical memory port between the instruction cache (read-only) and the data cache (read/write) in the split-cache LC-3b datapath.
- Sits between the two cache controllers and physical memory.
- Registers and holds each granted request until memory responds, then routes the response back to the owner.
- Provides bounded-starvation fixed priority: D-cache is favoured, but I-cache is guaranteed service.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one physical memory port between the I-cache (read-only) and the
// D-cache (read/write). Optional grant/conflict counters are enabled by MEM_ARBITER_STATS_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned LINE_WIDTH   = 128,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]           i_grant_count,
    output logic [31:0]           d_grant_count,
    output logic [31:0]           conflict_count
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [1:0]            state_q,  state_d;
    logic [3:0]            streak_q, streak_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [LINE_WIDTH-1:0] wdata_q,  wdata_d;
    logic                  write_q,  write_d;

    logic d_req;
    logic in_grant;

    assign d_req = d_read | d_write;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        case (state_q)
            S_IDLE: begin
                // D wins unless it has already starved a waiting I request for a full streak.
                if (d_req && !(i_read && streak_q >= STREAK_MAX)) begin
                    state_d  = S_GRANT_D;
                    addr_d   = d_address;
                    wdata_d  = d_wdata;
                    write_d  = d_write;
                    if (!i_read)
                        streak_d = 4'd0;
                    else if (streak_q != 4'hf)
                        streak_d = streak_q + 4'd1;
                end else if (i_read) begin
                    state_d  = S_GRANT_I;
                    addr_d   = i_address;
                    write_d  = 1'b0;
                    streak_d = 4'd0;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (pmem_resp)
                    state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            streak_q <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
        end
    end

    // Memory sees only the latched transaction; requester inputs are ignored while granted.
    assign in_grant     = (state_q == S_GRANT_I) || (state_q == S_GRANT_D);
    assign pmem_read    = in_grant && !write_q;
    assign pmem_write   = in_grant && write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = pmem_resp && (state_q == S_GRANT_I);
    assign d_resp  = pmem_resp && (state_q == S_GRANT_D);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] i_cnt_q, d_cnt_q, conf_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
            conf_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (state_d == S_GRANT_I)
                i_cnt_q <= i_cnt_q + 32'd1;
            if (state_d == S_GRANT_D)
                d_cnt_q <= d_cnt_q + 32'd1;
            if (i_read && d_req)
                conf_cnt_q <= conf_cnt_q + 32'd1;
        end
    end

    assign i_grant_count  = i_cnt_q;
    assign d_grant_count  = d_cnt_q;
    assign conflict_count = conf_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int LW   = 128;
    localparam int MAXS = 4;
    localparam int I_WAIT_BOUND = 64;

    logic          clk, reset;
    logic          i_read, i_resp;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          d_read, d_write, d_resp;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata, d_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0]   i_grant_count, d_grant_count, conflict_count;
`endif

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count),
        .conflict_count(conflict_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Transaction-level model: who owns memory, what was latched, and the D streak length.
    typedef enum int {OWN_NONE, OWN_I, OWN_D} owner_e;
    owner_e        m_owner;
    bit            m_release;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit            m_write;
    int            m_streak;
    int            m_igc, m_dgc, m_conf;
    int            i_wait;

    always @(negedge clk) begin
        bit dreq;
        if (reset) begin
            m_owner = OWN_NONE; m_release = 0; m_addr = '0; m_wdata = '0; m_write = 0;
            m_streak = 0; m_igc = 0; m_dgc = 0; m_conf = 0; i_wait = 0;
            check("rst_pmem_read", pmem_read, 0);
            check("rst_pmem_write", pmem_write, 0);
            check("rst_pmem_address", pmem_address, 0);
            check("rst_pmem_wdata", pmem_wdata, 0);
            check("rst_i_resp", i_resp, 0);
            check("rst_d_resp", d_resp, 0);
        end else begin
            check("m_pmem_read", pmem_read, (m_owner != OWN_NONE) && !m_write);
            check("m_pmem_write", pmem_write, (m_owner != OWN_NONE) && m_write);
            check("m_pmem_address", pmem_address, m_addr);
            check("m_pmem_wdata", pmem_wdata, m_wdata);
            check("m_i_resp", i_resp, (m_owner == OWN_I) && pmem_resp);
            check("m_d_resp", d_resp, (m_owner == OWN_D) && pmem_resp);
            if (i_resp) check("m_i_rdata", i_rdata, pmem_rdata);
            if (d_resp) check("m_d_rdata", d_rdata, pmem_rdata);
`ifdef MEM_ARBITER_STATS_EN
            check("m_i_grant_count", i_grant_count, m_igc);
            check("m_d_grant_count", d_grant_count, m_dgc);
            check("m_conflict_count", conflict_count, m_conf);
`endif
            if (i_read && i_resp) begin
                check("i_wait_bound", i_wait <= I_WAIT_BOUND, 1);
                i_wait = 0;
            end else if (i_read) i_wait++;
            else i_wait = 0;

            dreq = d_read | d_write;
            if (m_owner != OWN_NONE) begin
                if (pmem_resp) begin m_owner = OWN_NONE; m_release = 1; end
            end else if (m_release) begin
                m_release = 0;
            end else begin
                if (dreq && i_read) m_conf++;
                if (dreq && !(i_read && m_streak >= MAXS)) begin
                    m_owner = OWN_D; m_addr = d_address; m_wdata = d_wdata; m_write = d_write;
                    m_streak = i_read ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
                    m_dgc++;
                end else if (i_read) begin
                    m_owner = OWN_I; m_addr = i_address; m_write = 0; m_streak = 0;
                    m_igc++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe();
        for (int k = 0; k < 20; k++) begin
            if (pmem_read || pmem_write) break;
            step();
        end
        check("strobe_wait", pmem_read | pmem_write, 1);
    endtask

    bit i_got, d_got;
    int mem_wait, mem_lat;

    task automatic rand_cycle();
        step();
        if (i_got) i_read = 0;
        else if (!i_read && $urandom_range(2) == 0) begin
            i_read = 1; i_address = AW'($urandom);
        end
        if (d_got) begin
            d_read = 0; d_write = 0;
        end else if (!(d_read | d_write) && $urandom_range(2) == 0) begin
            case ($urandom_range(2))
                0:       begin d_read = 1; d_write = 0; end
                1:       begin d_read = 0; d_write = 1; end
                default: begin d_read = 1; d_write = 1; end
            endcase
            d_address = AW'($urandom); d_wdata = rand_line();
        end else if ((d_read | d_write) && $urandom_range(40) == 0) begin
            d_address = AW'($urandom); d_wdata = rand_line();
        end else if ((d_read | d_write) && $urandom_range(60) == 0) begin
            d_read = 0; d_write = 0;
        end
        pmem_resp = 0;
        if (pmem_read || pmem_write) begin
            mem_wait++;
            if (mem_wait >= mem_lat) begin
                pmem_resp = 1; pmem_rdata = rand_line();
                mem_wait = 0; mem_lat = $urandom_range(4, 1);
            end
        end else begin
            mem_wait = 0;
            if ($urandom_range(9) == 0) begin pmem_resp = 1; pmem_rdata = rand_line(); end
        end
        #1;
        i_got = i_resp;
        d_got = d_resp;
    endtask

    initial begin
        clk = 0; reset = 1;
        i_read = 0; i_address = '0;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;
        i_got = 0; d_got = 0; mem_wait = 0; mem_lat = 2;
        step(); step();
        reset = 0;
        step();

        // I-only read, response on the third grant cycle
        i_read = 1; i_address = 16'h1000;
        step();
        check("t1_pmem_read", pmem_read, 1);
        check("t1_pmem_address", pmem_address, 16'h1000);
        step(); step();
        pmem_resp = 1; pmem_rdata = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
        #1;
        check("t1_i_resp", i_resp, 1);
        check("t1_i_rdata", i_rdata, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
        check("t1_d_resp", d_resp, 0);
        step();
        pmem_resp = 0; i_read = 0;
        check("t1_release_read", pmem_read, 0);
        step();

        // Simultaneous requests: D write first, its address frozen while granted, then I
        i_read = 1; i_address = 16'h2000;
        d_write = 1; d_address = 16'h3000; d_wdata = {4{32'hDEAD_BEEF}};
        step();
        check("t2_d_write", pmem_write, 1);
        check("t2_d_address", pmem_address, 16'h3000);
        check("t2_d_wdata", pmem_wdata, {4{32'hDEAD_BEEF}});
        d_address = 16'h4000;
        step();
        check("t4_addr_frozen", pmem_address, 16'h3000);
        pmem_resp = 1;
        #1;
        check("t2_d_resp", d_resp, 1);
        check("t2_no_i_resp", i_resp, 0);
        step();
        pmem_resp = 0; d_write = 0;
        wait_strobe();
        check("t2_i_read", pmem_read, 1);
        check("t2_i_address", pmem_address, 16'h2000);
        pmem_resp = 1;
        #1;
        check("t2_i_resp", i_resp, 1);
        step();
        pmem_resp = 0; i_read = 0;
        step();

        // Starvation bound: order D,D,D,D,I,D
        i_read = 1; i_address = 16'hA000;
        d_read = 1; d_address = 16'hB000;
        for (int g = 0; g < 6; g++) begin
            wait_strobe();
            check("t3_grant_addr", pmem_address, (g == 4) ? 16'hA000 : 16'hB000);
            pmem_resp = 1;
            #1;
            check("t3_i_resp", i_resp, g == 4);
            check("t3_d_resp", d_resp, g != 4);
            step();
            pmem_resp = 0;
            if (g == 4) i_read = 0;
            if (g == 5) d_read = 0;
        end
        step();

        // Async reset while D is granted, then a late memory response
        d_write = 1; d_address = 16'h5000; d_wdata = rand_line();
        wait_strobe();
        #2 reset = 1;
        #1;
        check("t5_write_drop", pmem_write, 0);
        check("t5_addr_clear", pmem_address, 0);
`ifdef MEM_ARBITER_STATS_EN
        check("t5_i_cnt", i_grant_count, 0);
        check("t5_d_cnt", d_grant_count, 0);
        check("t5_conf_cnt", conflict_count, 0);
`endif
        @(posedge clk);
        #1;
        reset = 0; d_write = 0; pmem_resp = 1;
        #1;
        check("t5_late_d_resp", d_resp, 0);
        step();
        pmem_resp = 0;
        check("t5_idle_write", pmem_write, 0);
        check("t5_idle_read", pmem_read, 0);

        // Stray response while idle
        pmem_resp = 1;
        #1;
        check("t6_stray_i_resp", i_resp, 0);
        check("t6_stray_d_resp", d_resp, 0);
        step();
        pmem_resp = 0;
        check("t6_stray_strobe", pmem_read | pmem_write, 0);
        step();

        // Randomized traffic with random memory latency, stray responses and resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(599) == 0) begin
                step();
                reset = 1; pmem_resp = 0; mem_wait = 0; i_got = 0; d_got = 0;
                step();
                reset = 0;
            end
            rand_cycle();
        end

        step();
        i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
